// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the XOR-parity serial link: FSM encodings and parity sense constants.
package serial_parity_rx_pkg;

   // Frame FSM encodings, shared with the matching transmitter.
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StData   = 3'd1;
   localparam logic [2:0] StParity = 3'd2;
   localparam logic [2:0] StStop   = 3'd3;
   localparam logic [2:0] StWaitHi = 3'd4;

   localparam logic ParEven = 1'b0;
   localparam logic ParOdd  = 1'b1;

   // Maps the integer parity-mode parameter to the bit folded into the parity check.
   function automatic logic par_sense(input int unsigned odd);
      return (odd != 0) ? ParOdd : ParEven;
   endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Valid/ready output channel carrying a received word and its error flags.
interface serial_parity_rx_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_perr;
   logic              out_ferr;
   logic              out_ready;

   modport master (
      output out_data,
      output out_valid,
      output out_perr,
      output out_ferr,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_perr,
      input  out_ferr,
      output out_ready
   );

endinterface

// File: rtl/xor_parity_acc.sv
// Running XOR register; clear wins over enable. Also used by the transmitter for parity generation.
module xor_parity_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic acc
);

   logic acc_q;

   // Accumulate the XOR of every enabled input bit since the last clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= 1'b0;
      end else if (clr) begin
         acc_q <= 1'b0;
      end else if (en) begin
         acc_q <= acc_q ^ d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver for start/data(LSB first)/parity/stop frames with a one-entry valid/ready output buffer.
module serial_parity_rx
   import serial_parity_rx_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ODD    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               bit_en,
   input  logic               rx_in,
   serial_parity_rx_if.master out_if,
   output logic               overrun
);

   localparam int unsigned CntW     = $clog2(DATA_W + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
   localparam logic        ParSense = par_sense(ODD);

   logic [2:0]        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              done_q, done_d;
   logic              acc_clr, acc_en, acc;

   logic [DATA_W-1:0] data_q, data_d;
   logic              vld_q, vld_d;
   logic              bperr_q, bperr_d;
   logic              bferr_q, bferr_d;
   logic              ovr_q, ovr_d;

   xor_parity_acc u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .d     (rx_in),
      .acc   (acc)
   );

   // Frame FSM: advances only on bit strobes; done_d pulses on the stop-bit sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      if (bit_en) begin
         case (state_q)
            StIdle: begin
               if (!rx_in) begin
                  state_d = StData;
                  cnt_d   = '0;
                  acc_clr = 1'b1;
               end
            end
            StData: begin
               // Shifting right DATA_W times leaves the first (LSB) bit at position 0.
               shift_d = {rx_in, shift_q[DATA_W-1:1]};
               acc_en  = 1'b1;
               cnt_d   = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  state_d = StParity;
               end
            end
            StParity: begin
               perr_d  = acc ^ rx_in ^ ParSense;
               state_d = StStop;
            end
            StStop: begin
               ferr_d  = ~rx_in;
               done_d  = 1'b1;
               state_d = rx_in ? StIdle : StWaitHi;
            end
            StWaitHi: begin
               // A low line here is a stuck/broken line, not a start bit.
               if (rx_in) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Output buffer: consume, load on completion, or drop and flag overrun when full.
   always_comb begin
      data_d  = data_q;
      vld_d   = vld_q;
      bperr_d = bperr_q;
      bferr_d = bferr_q;
      ovr_d   = ovr_q;
      if (vld_q && out_if.out_ready) begin
         vld_d = 1'b0;
      end
      if (done_q) begin
         if (!vld_q || out_if.out_ready) begin
            data_d  = shift_q;
            bperr_d = perr_q;
            bferr_d = ferr_q;
            vld_d   = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // State registers for the FSM and the output buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         bperr_q <= 1'b0;
         bferr_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         bperr_q <= bperr_d;
         bferr_q <= bferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_if.out_data  = data_q;
   assign out_if.out_valid = vld_q;
   assign out_if.out_perr  = bperr_q;
   assign out_if.out_ferr  = bferr_q;
   assign overrun          = ovr_q;

endmodule
